// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory request, owns the pc,
// and fills the IF/ID pipeline register. A one-entry skid buffer catches a word
// that completes while decode is stalled. Jumps and taken branches resolved in
// decode redirect the pc.
// Optional feature: define DELAY_SLOT_EN to keep and execute the instruction at
// branch/jump PC+4 (MIPS delay slot) instead of flushing it.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic [1:0]  Jump,
  input  logic        Branch,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    HOLD       = 2'd1,
    REDIR_WAIT = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr_n, pc4_n;
  logic        valid_n;
  logic [31:0] skid_instr, skid_n;

`ifdef DELAY_SLOT_EN
  // Target held while the delay-slot instruction is still outstanding.
  logic        redir_pend, redir_pend_n;
  logic [31:0] redir_tgt, redir_tgt_n;
`endif

  logic [31:0] seq_pc;
  logic [31:0] jump_target;
  logic        redirect;
  logic [31:0] redir_target;
  logic [31:0] accept_pc;

  assign imem_addr = pc;
  assign opcode    = if_id_instr[31:26];
  assign funct     = if_id_instr[5:0];
  assign seq_pc    = pc + 32'd4;
  assign jump_target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};

  // Redirect decision for the instruction sitting in IF/ID; Jump==3 is ignored.
  always_comb begin
    redirect     = 1'b0;
    redir_target = seq_pc;
    if (if_id_valid && !stall) begin
      if (Jump == 2'd2) begin
        redirect     = 1'b1;
        redir_target = jr_target;
      end else if (Jump == 2'd1) begin
        redirect     = 1'b1;
        redir_target = jump_target;
      end else if (Branch && branch_taken) begin
        redirect     = 1'b1;
        redir_target = branch_target;
      end
    end
  end

  // pc value to load when a word is accepted into IF/ID.
  always_comb begin
`ifdef DELAY_SLOT_EN
    if (redirect)
      accept_pc = redir_target;
    else if (redir_pend)
      accept_pc = redir_tgt;
    else
      accept_pc = seq_pc;
`else
    accept_pc = seq_pc;
`endif
  end

  // Request is withheld only while parked in HOLD or held in reset.
  always_comb begin
    imem_req = (state != HOLD) && !reset;
  end

  // Next-state and next register values for the whole stage.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = if_id_instr;
    pc4_n   = if_id_pc4;
    valid_n = if_id_valid;
    skid_n  = skid_instr;
`ifdef DELAY_SLOT_EN
    redir_pend_n = redir_pend;
    redir_tgt_n  = redir_tgt;
`endif

    case (state)
      HOLD: begin
        if (!stall) begin
          instr_n = skid_instr;
          pc4_n   = seq_pc;
          valid_n = 1'b1;
          pc_n    = accept_pc;
          state_n = FETCH;
          skid_n  = 32'd0;
`ifdef DELAY_SLOT_EN
          redir_pend_n = 1'b0;
`endif
        end
      end
      default: begin
        // FETCH, and REDIR_WAIT which is FETCH with a pending target.
        if (imem_ready) begin
          if (!stall) begin
            instr_n = imem_data;
            pc4_n   = seq_pc;
            valid_n = 1'b1;
            pc_n    = accept_pc;
            state_n = FETCH;
`ifdef DELAY_SLOT_EN
            redir_pend_n = 1'b0;
`endif
          end else begin
            skid_n  = imem_data;
            state_n = HOLD;
          end
        end else if (!stall) begin
          valid_n = 1'b0;
`ifdef DELAY_SLOT_EN
          // Delay slot not yet returned: park the target until it is.
          if (redirect) begin
            redir_pend_n = 1'b1;
            redir_tgt_n  = redir_target;
            state_n      = REDIR_WAIT;
          end
`endif
        end
      end
    endcase

`ifndef DELAY_SLOT_EN
    // Flush: the word at pc is the wrong path, drop it and refetch at target.
    if (redirect) begin
      pc_n    = redir_target;
      valid_n = 1'b0;
      skid_n  = 32'd0;
      state_n = FETCH;
    end
`endif
  end

  // State, pc, IF/ID and skid registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      if_id_instr <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      skid_instr  <= 32'd0;
`ifdef DELAY_SLOT_EN
      redir_pend  <= 1'b0;
      redir_tgt   <= 32'd0;
`endif
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_id_instr <= instr_n;
      if_id_pc4   <= pc4_n;
      if_id_valid <= valid_n;
      skid_instr  <= skid_n;
`ifdef DELAY_SLOT_EN
      redir_pend  <= redir_pend_n;
      redir_tgt   <= redir_tgt_n;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory returns 0xA000_0000+addr
// for every word except where a test plants an instruction. Expected values
// follow DELAY_SLOT_EN when the bench is built with it.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        stall;
  logic [1:0]  Jump;
  logic        Branch;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] jr_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  logic [31:0] mem [256];
  int n_vec  = 0;
  int n_miss = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_data(imem_data), .imem_ready(imem_ready), .stall(stall),
    .Jump(Jump), .Branch(Branch), .branch_taken(branch_taken),
    .branch_target(branch_target), .jr_target(jr_target),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .opcode(opcode), .funct(funct)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic vld);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc4"},   if_id_pc4,   pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, vld});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst.req", {31'd0, imem_req}, 32'd0);
    tick();
    tick();
    check("rst.addr", imem_addr, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    check("rst.req_after", {31'd0, imem_req}, 32'd1);
    check("rst.addr_after", imem_addr, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i) * 32'd4;
    reset = 1'b1; imem_ready = 1'b1; stall = 1'b0; Jump = 2'd0;
    Branch = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; jr_target = 32'h0;
    tick();

    // Back-to-back fetch A, B, C.
    do_reset();
    tick(); check_ifid("seqA", 32'hA000_0000, 32'd4, 1'b1);
    tick(); check_ifid("seqB", 32'hA000_0004, 32'd8, 1'b1);
    tick(); check_ifid("seqC", 32'hA000_0008, 32'd12, 1'b1);
    check("seq.addr", imem_addr, 32'd12);

    // Stall for three cycles while B completes.
    do_reset();
    tick(); check_ifid("stA", 32'hA000_0000, 32'd4, 1'b1);
    stall = 1'b1;
    tick(); check_ifid("st1", 32'hA000_0000, 32'd4, 1'b1);
    check("st1.req", {31'd0, imem_req}, 32'd0);
    tick(); check("st2.instr", if_id_instr, 32'hA000_0000);
    tick(); check("st3.req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick(); check_ifid("stB", 32'hA000_0004, 32'd8, 1'b1);
    check("stB.req", {31'd0, imem_req}, 32'd1);
    check("stB.addr", imem_addr, 32'd8);

    // Memory not ready for two cycles, then reset while parked in HOLD.
    imem_ready = 1'b0;
    tick(); check("nr1.valid", {31'd0, if_id_valid}, 32'd0); check("nr1.addr", imem_addr, 32'd8);
    tick(); check("nr2.valid", {31'd0, if_id_valid}, 32'd0); check("nr2.addr", imem_addr, 32'd8);
    imem_ready = 1'b1; stall = 1'b1;
    tick(); check("hold.req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    do_reset();

    // j with instr_index 0x10 at address 4.
    mem[1] = 32'h0800_0010;
    tick(); check_ifid("jA", 32'hA000_0000, 32'd4, 1'b1);
    tick(); check_ifid("jI", 32'h0800_0010, 32'd8, 1'b1);
    check("j.opcode", {26'd0, opcode}, 32'd2);
    check("j.funct", {26'd0, funct}, 32'h10);
    Jump = 2'd1;
    tick();
    Jump = 2'd0;
    check("j.addr", imem_addr, 32'h40);
`ifdef DELAY_SLOT_EN
    check_ifid("j.slot", 32'hA000_0008, 32'hC, 1'b1);
`else
    check("j.flush", {31'd0, if_id_valid}, 32'd0);
`endif
    tick(); check_ifid("j.tgt", 32'hA000_0040, 32'h44, 1'b1);

    // Taken beq to 0x100.
    Branch = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    Branch = 1'b0; branch_taken = 1'b0;
    check("br.addr", imem_addr, 32'h100);
`ifdef DELAY_SLOT_EN
    check_ifid("br.slot", 32'hA000_0044, 32'h48, 1'b1);
`else
    check("br.flush", {31'd0, if_id_valid}, 32'd0);
`endif
    tick(); check_ifid("br.tgt", 32'hA000_0100, 32'h104, 1'b1);

    // jr to the top of the address space with memory not ready; pc wraps after.
    Jump = 2'd2; jr_target = 32'hFFFF_FFFC; imem_ready = 1'b0;
    tick();
    Jump = 2'd0; imem_ready = 1'b1;
    check("jr.valid", {31'd0, if_id_valid}, 32'd0);
`ifdef DELAY_SLOT_EN
    check("jr.wait_addr", imem_addr, 32'h104);
    tick(); check_ifid("jr.slot", 32'hA000_0104, 32'h108, 1'b1);
`endif
    check("jr.addr", imem_addr, 32'hFFFF_FFFC);
    tick(); check_ifid("jr.tgt", 32'hA000_03FC, 32'h0, 1'b1);
    check("wrap.addr", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_addr  out  32  fetch address, equal to the pc register.
REQ-005 SHALL have port imem_req  out  1  fetch request.
REQ-006 SHALL have port imem_data  in  32  instruction word, valid when imem_ready=1.
REQ-007 SHALL have port imem_ready  in  1  fetch completes in a cycle where imem_req=1 and imem_ready=1.
REQ-008 SHALL have port stall  in  1  hazard hold: IF/ID and pc frozen.
REQ-009 SHALL have port Jump  in  2  0 = none, 1 = j/jal, 2 = jr, 3 = treated as 0; qualifies the IF/ID instruction.
REQ-010 SHALL have port Branch  in  1  the IF/ID instruction is beq/bne.
REQ-011 SHALL have port branch_taken  in  1  branch condition resolved true.
REQ-012 SHALL have port branch_target  in  32  PC+4+(sext(imm)<<2).
REQ-013 SHALL have port jr_target  in  32  rs value for jr.
REQ-014 SHALL have port if_id_instr  out  32  registered instruction.
REQ-015 SHALL have port if_id_pc4  out  32  registered fetch address + 4.
REQ-016 SHALL have port if_id_valid  out  1  IF/ID holds a real instruction.
REQ-017 SHALL have ports opcode  out  6 = if_id_instr[31:26] and funct  out  6 = if_id_instr[5:0], which drive the control decoder.

Function
REQ-018 SHALL implement states FETCH, HOLD and REDIR_WAIT.
REQ-019 SHALL, in FETCH, assert imem_req=1; on imem_ready=1 with stall=0, load IF/ID with imem_data, if_id_pc4=pc+4 and valid=1, advance pc to next_pc in the same cycle, and remain in FETCH (throughput one per cycle, latency one cycle from handshake to IF/ID).
REQ-020 SHALL, in FETCH with imem_ready=1 and stall=1, capture imem_data into a one-entry skid buffer, keep IF/ID unchanged, and go to HOLD.
REQ-021 SHALL, in FETCH with imem_ready=0: if stall=1, hold IF/ID; otherwise load if_id_valid=0 (bubble) and keep pc.
REQ-022 SHALL, in HOLD, drive imem_req=0; when stall=0, move the skid buffer into IF/ID (valid=1), advance pc, and return to FETCH.
REQ-023 SHALL evaluate a redirect only when if_id_valid=1 and stall=0, with priority Jump==2 -> jr_target; then Jump==1 -> {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}; then Branch && branch_taken -> branch_target; otherwise pc+4.
REQ-024 SHALL, whenever pc is updated, perform all address arithmetic modulo 2^32, so that 32'hFFFF_FFFC+4 wraps to 0.
REQ-025 SHALL, on a redirect without DELAY_SLOT_EN, load pc with the target, discard any instruction completing that cycle (if_id_valid=0), and clear the skid buffer.
REQ-026 SHALL change imem_addr while imem_req=1 only on a redirect; the outstanding request is abandoned and reissued at the new address.
REQ-027 SHALL, if a redirect occurs with stall=0 in HOLD, take the redirect and discard the skid entry.

Reset
REQ-028 SHALL, while reset=1, set pc=RESET_PC, state=FETCH, imem_req=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0, skid buffer empty and redirect register cleared; reset SHALL override all other inputs, including mid-fetch and mid-HOLD.
REQ-029 SHALL assert imem_req=1 at RESET_PC in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL use macro DELAY_SLOT_EN; when it is defined, the instruction at branch/jump PC+4 SHALL be kept and executed, with the target saved in a redirect register and applied to pc when that delay-slot instruction is accepted into IF/ID.
REQ-031 SHALL, with DELAY_SLOT_EN defined and imem_ready=0 at the redirect, wait for the delay-slot fetch in state REDIR_WAIT; without the macro, REDIR_WAIT SHALL be unreachable and the flush of REQ-025 SHALL apply.

Verification
REQ-032 SHALL cover: reset, then imem_ready=1 always with words A, B, C -> IF/ID shows A/pc4=4, B/8, C/12 on consecutive cycles.
REQ-033 SHALL cover: stall=1 for 3 cycles while word B completes -> IF/ID holds A, imem_req=0 in HOLD, B appears the cycle after stall drops.
REQ-034 SHALL cover: a j instruction in IF/ID with instr_index=26'h10, Jump=1 -> next imem_addr=32'h40 and the flushed slot gives if_id_valid=0 (macro off).
REQ-035 SHALL cover: beq taken with branch_target=32'h100 and DELAY_SLOT_EN defined -> the pc+4 instruction is valid in IF/ID, then imem_addr=32'h100.
REQ-036 SHALL cover: imem_ready=0 for 2 cycles -> if_id_valid=0 bubbles, pc unchanged; then reset asserted in HOLD -> pc=RESET_PC, valid=0 next cycle.
